whirlpool_compress_ctrl: RTL
============================

// Module: whirlpool_compress_ctrl
// PURPOSE
// Iterative Whirlpool compression-function sequencer. Accepts one 512-bit message block plus
// a 512-bit chaining value. Time-shares a single process_round instance between the key
// schedule and the data path, alternating key and data rounds for ROUNDS rounds. Returns the
// Miyaguchi-Preneel result H' = E_H(M) ^ M ^ H. Sits between the miner's block/nonce
// feeder and the hash-compare stage.
// PARAMETERS
// ROUNDS  10  cipher rounds executed, legal 1..10 (round-constant ROM holds RC1..RC10)
// PORTS
// clk        in   1    rising-edge clock
// reset      in   1    asynchronous, active-high; clears all state
// in_valid   in   1    in_block/in_chain valid
// in_ready   out  1    controller can accept a job (high only in IDLE)
// in_block   in   512  message block M, byte 0 in bits [511:504]
// in_chain   in   512  chaining value H, same byte order
// out_valid  out  1    out_hash valid; held until out_ready
// out_ready  in   1    downstream accepts out_hash
// out_hash   out  512  E_H(M) ^ M ^ H
// busy       out  1    high in KEY or DATA
// round_idx  out  4    current round r (1..ROUNDS); 0 in IDLE
// BEHAVIOUR
// Reset: FSM=IDLE, in_ready=1 once reset deasserts, out_valid=0, busy=0, round_idx=0,
//   out_hash=0. All internal registers (M_r, H_r, K_r, S_r) are cleared to 0.
// Registers: M_r, H_r, K_r (round key), S_r (state), rnd[3:0]. One shared
//   process_round(block=blk_mux, key=key_mux).
// FSM:
//   IDLE: in_ready=1. On in_valid&in_ready: M_r<=in_block, H_r<=in_chain, K_r<=in_chain,
//     S_r<=in_block^in_chain, rnd<=1, ->KEY. in_valid without a handshake has no effect.
//   KEY: blk_mux=K_r, key_mux={RC[rnd],448'b0}; K_r<=round_out; ->DATA.
//   DATA: blk_mux=S_r, key_mux=K_r (already updated); S_r<=round_out.
//     rnd==ROUNDS -> DONE, else rnd<=rnd+1 -> KEY.
//   DONE: out_valid=1, out_hash=S_r^M_r^H_r (registered on entry to DONE).
//     out_hash is stable while out_valid=1 && out_ready=0. On out_ready: ->IDLE.
// Round constants, RC[r] (64-bit, MSB = byte 0):
//   1:1823c6e887b8014f 2:36a6d2f5796f9152 3:60bc9b8ea30c7b35 4:1de0d7c22e4bfe57
//   5:157737e59ff04ada 6:58c9290ab1a06b85 7:bd5d10f4cb3e0567 8:e427418ba77d95d8
//   9:fbee7c66dd17479e 10:ca2dbf07ad5a8333
// Latency: out_valid rises exactly 2*ROUNDS clock edges after the accepting edge
//   (20 for ROUNDS=10). Throughput: one job per 2*ROUNDS+2 cycles when out_ready is held high.
// in_ready is 0 in KEY/DATA/DONE. Input changes while not in IDLE are ignored.
//   There is no same-cycle DONE->accept.
// round_idx=rnd in KEY/DATA/DONE.
// Reset mid-job (any state): immediate abort to reset values. No partial out_valid.
// Width rules: all XORs are 512-bit bitwise. rnd never exceeds ROUNDS and never wraps.
// TESTING
// T1 reset: assert reset mid-cycle -> in_ready=1 (post-release), out_valid=0, out_hash=0,
//    round_idx=0.
// T2 empty-string vector: H=0, M=80 00..00 (all-zero length) -> after 20 edges out_hash=
//    19fa61d75522a466...08b138cc42a66eb3 (full ISO vector), out_valid=1.
// T3 backpressure: T2 with out_ready=0 for 7 cycles -> out_valid and out_hash stable;
//    in_ready=0 throughout; IDLE on the first out_ready=1 edge.
// T4 busy-ignore: pulse in_valid with different data at cycles 3 and 15 of a job -> result
//    still equals the T2 value; no second job starts.
// T5 reset mid-job: assert reset when round_idx=5 -> out_valid never rises. A fresh T2 job
//    afterwards produces the correct hash.
// T6 back-to-back: two jobs, out_ready=1, second in_valid held high -> second accept exactly
//    2 cycles after first out_valid. Both hashes match the C model; round_idx steps 1..10.

Source files
------------

// File: rtl/whirlpool_compress_ctrl.sv
// Iterative Whirlpool compression-function sequencer.
//
// One combinational Whirlpool round (gamma, pi, theta, sigma) is shared between
// the key schedule and the data path. Each cipher round takes two cycles:
// first a KEY cycle (K <= rho[RC[r]](K)), then a DATA cycle (S <= rho[K](S)).
// After ROUNDS rounds the Miyaguchi-Preneel output E_H(M) ^ M ^ H is
// registered and held until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears every register
//   in_valid   in_block / in_chain carry a job
//   in_ready   job can be accepted (IDLE only)
//   in_block   message block M, byte 0 in bits [511:504]
//   in_chain   chaining value H, same byte order
//   out_valid  out_hash valid, held until out_ready
//   out_ready  consumer takes out_hash
//   out_hash   E_H(M) ^ M ^ H
//   busy       KEY or DATA cycle in progress
//   round_idx  current round 1..ROUNDS, 0 in IDLE
module whirlpool_compress_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic [511:0] in_chain,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_hash,
    output logic         busy,
    output logic [3:0]   round_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEY,
        S_DATA,
        S_DONE
    } state_t;

    // Mini-box tables of the Whirlpool S-box, nibble 0 in the top bits.
    localparam logic [63:0] E_TBL    = 64'h1B9CD6F3E874A250;
    localparam logic [63:0] EINV_TBL = 64'hF0D7BE5A92C13486;
    localparam logic [63:0] R_TBL    = 64'h7CBDE49F638A2510;
    // First row of the circulant MixRows matrix: 01 01 04 01 08 05 02 09.
    localparam logic [31:0] MIX_ROW  = 32'h11418529;

    state_t       state_q, state_d;
    logic [511:0] m_q, m_d;
    logic [511:0] h_q, h_d;
    logic [511:0] k_q, k_d;
    logic [511:0] s_q, s_d;
    logic [511:0] hash_q, hash_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [511:0] blk_mux;
    logic [511:0] key_mux;
    logic [511:0] round_out;

    function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] idx);
        int pos;
        pos = 15 - int'(idx);
        return tbl[pos*4 +: 4];
    endfunction

    // S-box built from the E, E^-1 and R mini-boxes.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        a = nib(E_TBL, x[7:4]);
        b = nib(EINV_TBL, x[3:0]);
        r = nib(R_TBL, a ^ b);
        return {nib(E_TBL, a ^ r), nib(EINV_TBL, b ^ r)};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x^2 + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by a constant below 16 (all MixRows coefficients are).
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [3:0] mix_coef(input int idx);
        return MIX_ROW[(7 - idx)*4 +: 4];
    endfunction

    // One Whirlpool round on an 8x8 byte matrix, byte 8*row+col.
    function automatic logic [511:0] process_round(input logic [511:0] blk,
                                                   input logic [511:0] key);
        logic [7:0]   sub [64];
        logic [7:0]   shf [64];
        logic [7:0]   acc;
        logic [511:0] res;
        res = '0;
        for (int n = 0; n < 64; n++) begin
            sub[n] = sbox(blk[511-8*n -: 8]);
        end
        // Column j rotates down by j rows.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                shf[8*i+j] = sub[8*((i-j+8)%8)+j];
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = key[511-8*(8*i+j) -: 8];
                for (int t = 0; t < 8; t++) begin
                    acc = acc ^ gmul(shf[8*i+t], mix_coef((j-t+8)%8));
                end
                res[511-8*(8*i+j) -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [63:0] rc_rom(input logic [3:0] r);
        logic [63:0] rc;
        case (r)
            4'd1:    rc = 64'h1823c6e887b8014f;
            4'd2:    rc = 64'h36a6d2f5796f9152;
            4'd3:    rc = 64'h60bc9b8ea30c7b35;
            4'd4:    rc = 64'h1de0d7c22e4bfe57;
            4'd5:    rc = 64'h157737e59ff04ada;
            4'd6:    rc = 64'h58c9290ab1a06b85;
            4'd7:    rc = 64'hbd5d10f4cb3e0567;
            4'd8:    rc = 64'he427418ba77d95d8;
            4'd9:    rc = 64'hfbee7c66dd17479e;
            4'd10:   rc = 64'hca2dbf07ad5a8333;
            default: rc = 64'h0;
        endcase
        return rc;
    endfunction

    // Shared round operands: key schedule in KEY, data path otherwise.
    always_comb begin
        blk_mux = s_q;
        key_mux = k_q;
        if (state_q == S_KEY) begin
            blk_mux = k_q;
            key_mux = {rc_rom(rnd_q), 448'b0};
        end
    end

    assign round_out = process_round(blk_mux, key_mux);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        h_d     = h_q;
        k_d     = k_q;
        s_d     = s_q;
        hash_d  = hash_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d     = in_block;
                    h_d     = in_chain;
                    k_d     = in_chain;
                    s_d     = in_block ^ in_chain;
                    rnd_d   = 4'd1;
                    state_d = S_KEY;
                end
            end
            S_KEY: begin
                k_d     = round_out;
                state_d = S_DATA;
            end
            S_DATA: begin
                s_d = round_out;
                if (rnd_q == 4'(ROUNDS)) begin
                    hash_d  = round_out ^ m_q ^ h_q;
                    state_d = S_DONE;
                end else begin
                    rnd_d   = rnd_q + 4'd1;
                    state_d = S_KEY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    rnd_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                rnd_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            h_q     <= '0;
            k_q     <= '0;
            s_q     <= '0;
            hash_q  <= '0;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            h_q     <= h_d;
            k_q     <= k_d;
            s_q     <= s_d;
            hash_q  <= hash_d;
            rnd_q   <= rnd_d;
        end
    end

    // in_ready is held low while reset is asserted so no job is taken then.
    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_KEY) || (state_q == S_DATA);
    assign round_idx = rnd_q;
    assign out_hash  = hash_q;

endmodule
